// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the fetch PC, runs the imem req/ready
// handshake and fills the IF/ID register, applying redirects and stalls.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] fetch_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr
);

    typedef enum logic [1:0] {BOOT, FETCH, KILL, HOLD} state_t;

    state_t      state_q;
    logic        imem_req_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] pending_pc_q;
    logic [31:0] hold_instr_q;
    logic        if_id_valid_q;
    logic [31:0] if_id_pc_q;
    logic [31:0] if_id_pc_plus4_q;
    logic [31:0] if_id_instr_q;

    logic [31:0] pc_plus4;
    logic [31:0] target_pc;

    assign pc_plus4  = fetch_pc_q + 32'd4;
    assign target_pc = redirect_pc & 32'hFFFF_FFFC;

    // imem_addr comes straight from the PC register, so it cannot move while
    // a request is outstanding; KILL parks the redirect target in pending_pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= BOOT;
            imem_req_q       <= 1'b0;
            fetch_pc_q       <= RESET_PC;
            pending_pc_q     <= 32'h0;
            hold_instr_q     <= 32'h0;
            if_id_valid_q    <= 1'b0;
            if_id_pc_q       <= 32'h0;
            if_id_pc_plus4_q <= 32'h0;
            if_id_instr_q    <= NOP_INSTR;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q    <= FETCH;
                    imem_req_q <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready) begin
                        if (redirect) begin
                            fetch_pc_q    <= target_pc;
                            if_id_valid_q <= 1'b0;
                            if_id_instr_q <= NOP_INSTR;
                        end else if (stall) begin
                            hold_instr_q <= imem_rdata;
                            state_q      <= HOLD;
                            imem_req_q   <= 1'b0;
                        end else begin
                            if_id_valid_q    <= 1'b1;
                            if_id_pc_q       <= fetch_pc_q;
                            if_id_pc_plus4_q <= pc_plus4;
                            if_id_instr_q    <= imem_rdata;
                            fetch_pc_q       <= pc_plus4;
                        end
                    end else if (redirect) begin
                        pending_pc_q  <= target_pc;
                        if_id_valid_q <= 1'b0;
                        if_id_instr_q <= NOP_INSTR;
                        state_q       <= KILL;
                    end else if (!stall) begin
                        if_id_valid_q <= 1'b0;
                        if_id_instr_q <= NOP_INSTR;
                    end
                end
                KILL: begin
                    if (redirect)
                        pending_pc_q <= target_pc;
                    if (redirect || !stall) begin
                        if_id_valid_q <= 1'b0;
                        if_id_instr_q <= NOP_INSTR;
                    end
                    // stale response is dropped; the target goes out next cycle
                    if (imem_ready) begin
                        fetch_pc_q <= redirect ? target_pc : pending_pc_q;
                        state_q    <= FETCH;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        fetch_pc_q    <= target_pc;
                        if_id_valid_q <= 1'b0;
                        if_id_instr_q <= NOP_INSTR;
                        state_q       <= FETCH;
                        imem_req_q    <= 1'b1;
                    end else if (!stall) begin
                        if_id_valid_q    <= 1'b1;
                        if_id_pc_q       <= fetch_pc_q;
                        if_id_pc_plus4_q <= pc_plus4;
                        if_id_instr_q    <= hold_instr_q;
                        fetch_pc_q       <= pc_plus4;
                        state_q          <= FETCH;
                        imem_req_q       <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= BOOT;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req       = imem_req_q;
    assign imem_addr      = fetch_pc_q;
    assign fetch_pc       = fetch_pc_q;
    assign if_id_valid    = if_id_valid_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign if_id_instr    = if_id_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycles push expected handshakes and IF/ID
// loads into queues; a monitor pops and compares them as the DUT shows them.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] fetch_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } ifid_t;

    ifid_t       exp_i[$];
    logic [31:0] exp_a[$];
    int          nchk  = 0;
    int          nfail = 0;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .fetch_pc      (fetch_pc),
        .if_id_valid   (if_id_valid),
        .if_id_pc      (if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_instr   (if_id_instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; memory returns addr as data.
    task automatic go(input logic rdy, input logic rdr, input logic [31:0] rpc, input logic stl);
        @(negedge clk);
        imem_ready  = rdy;
        imem_rdata  = imem_addr;
        redirect    = rdr;
        redirect_pc = rpc;
        stall       = stl;
    endtask

    task automatic push_a(input logic [31:0] a);
        exp_a.push_back(a);
    endtask

    task automatic push_i(input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] instr);
        ifid_t e;
        e.pc = pc; e.pc4 = pc4; e.instr = instr;
        exp_i.push_back(e);
    endtask

    // Monitor: a valid IF/ID after a non-stall cycle is a fresh load.
    initial begin
        logic  prev_stall;
        ifid_t e;
        logic [31:0] a;
        prev_stall = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_stall = 1'b1;
                continue;
            end
            if (if_id_valid && !prev_stall) begin
                nchk++;
                if (exp_i.size() == 0) begin
                    nfail++;
                    $display("FAIL ifid_unexpected actual_pc=%h expected=none", if_id_pc);
                end else begin
                    e = exp_i.pop_front();
                    if (if_id_pc !== e.pc || if_id_pc_plus4 !== e.pc4 || if_id_instr !== e.instr) begin
                        nfail++;
                        $display("FAIL ifid actual=%h/%h/%h expected=%h/%h/%h",
                                 if_id_pc, if_id_pc_plus4, if_id_instr, e.pc, e.pc4, e.instr);
                    end
                end
            end
            if (imem_req && imem_ready) begin
                nchk++;
                if (exp_a.size() == 0) begin
                    nfail++;
                    $display("FAIL hs_unexpected actual_addr=%h expected=none", imem_addr);
                end else begin
                    a = exp_a.pop_front();
                    if (imem_addr !== a) begin
                        nfail++;
                        $display("FAIL hs_addr actual=%h expected=%h", imem_addr, a);
                    end
                end
            end
            prev_stall = stall;
        end
    end

    initial begin
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        imem_ready = 1'b0; imem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req",   {31'b0, imem_req},    32'h0);
        chk("rst_pc",    fetch_pc,             32'h0);
        chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rst_instr", if_id_instr,          32'h13);
        chk("rst_ifpc",  if_id_pc,             32'h0);
        chk("rst_ifpc4", if_id_pc_plus4,       32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait streaming.
        go(1, 0, 0, 0); chk("a0_req", {31'b0, imem_req}, 32'h1); chk("a0_addr", imem_addr, 32'h0);
        chk("a0_valid", {31'b0, if_id_valid}, 32'h0);
        push_a(32'h0); push_i(32'h0, 32'h4, 32'h0);
        go(1, 0, 0, 0); chk("a4_addr", imem_addr, 32'h4); chk("a4_valid", {31'b0, if_id_valid}, 32'h1);
        push_a(32'h4); push_i(32'h4, 32'h8, 32'h4);
        go(1, 0, 0, 0); chk("a8_addr", imem_addr, 32'h8);
        push_a(32'h8); push_i(32'h8, 32'hC, 32'h8);
        go(1, 0, 0, 0); chk("aC_addr", imem_addr, 32'hC);
        push_a(32'hC); push_i(32'hC, 32'h10, 32'hC);

        // Zero-wait redirect to 0x103 (aligned to 0x100).
        go(1, 1, 32'h103, 0); chk("r10_addr", imem_addr, 32'h10);
        push_a(32'h10);
        go(1, 0, 0, 0); chk("r100_addr", imem_addr, 32'h100);
        chk("r_bub_valid", {31'b0, if_id_valid}, 32'h0); chk("r_bub_instr", if_id_instr, 32'h13);
        chk("r_bub_pc", if_id_pc, 32'hC);
        push_a(32'h100); push_i(32'h100, 32'h104, 32'h100);
        go(0, 0, 0, 0); chk("r104_addr", imem_addr, 32'h104);

        // Redirect during a wait: 0x20 pending, redirect to 0x80 in the first cycle.
        go(1, 1, 32'h20, 0); chk("w_bub_valid", {31'b0, if_id_valid}, 32'h0);
        push_a(32'h104);
        go(0, 1, 32'h80, 0); chk("w_addr0", imem_addr, 32'h20); chk("w_req0", {31'b0, imem_req}, 32'h1);
        go(0, 0, 0, 0);      chk("w_addr1", imem_addr, 32'h20); chk("w_valid1", {31'b0, if_id_valid}, 32'h0);
        go(1, 0, 0, 0);      chk("w_addr2", imem_addr, 32'h20);
        push_a(32'h20);
        go(1, 0, 0, 0);      chk("w_tgt", imem_addr, 32'h80); chk("w_valid3", {31'b0, if_id_valid}, 32'h0);
        push_a(32'h80); push_i(32'h80, 32'h84, 32'h80);

        // Stall for two cycles as 0x40 returns.
        go(1, 1, 32'h3C, 0); chk("s84_addr", imem_addr, 32'h84);
        push_a(32'h84);
        go(1, 0, 0, 0); chk("s3C_addr", imem_addr, 32'h3C);
        push_a(32'h3C); push_i(32'h3C, 32'h40, 32'h3C);
        go(1, 0, 0, 1); chk("s40_addr", imem_addr, 32'h40);
        push_a(32'h40);
        go(1, 0, 0, 1); chk("s_req0", {31'b0, imem_req}, 32'h0); chk("s_hold0", if_id_instr, 32'h3C);
        go(1, 0, 0, 0); chk("s_req1", {31'b0, imem_req}, 32'h0); chk("s_hold1", if_id_instr, 32'h3C);
        push_i(32'h40, 32'h44, 32'h40);
        go(1, 0, 0, 0); chk("s44_addr", imem_addr, 32'h44); chk("s_rel_instr", if_id_instr, 32'h40);
        push_a(32'h44); push_i(32'h44, 32'h48, 32'h44);

        // PC wrap at the top of the address space.
        go(1, 1, 32'hFFFF_FFFC, 0); chk("x48_addr", imem_addr, 32'h48);
        push_a(32'h48);
        go(1, 0, 0, 0); chk("xtop_addr", imem_addr, 32'hFFFF_FFFC);
        push_a(32'hFFFF_FFFC); push_i(32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC);
        go(1, 0, 0, 0); chk("xwrap_addr", imem_addr, 32'h0); chk("xwrap_pc4", if_id_pc_plus4, 32'h0);
        push_a(32'h0); push_i(32'h0, 32'h4, 32'h0);
        go(0, 0, 0, 0); chk("x4_addr", imem_addr, 32'h4);

        // Reset while in KILL with a request outstanding.
        go(0, 1, 32'h200, 0); chk("k_addr0", imem_addr, 32'h4);
        go(0, 0, 0, 0);       chk("k_addr1", imem_addr, 32'h4); chk("k_req", {31'b0, imem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("kr_req",   {31'b0, imem_req},    32'h0);
        chk("kr_pc",    fetch_pc,             32'h0);
        chk("kr_valid", {31'b0, if_id_valid}, 32'h0);
        chk("kr_instr", if_id_instr,          32'h13);
        chk("kr_ifpc4", if_id_pc_plus4,       32'h0);
        @(negedge clk);
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("kr_req2", {31'b0, imem_req}, 32'h0);
        rst_n = 1'b1;
        go(1, 0, 0, 0); chk("kb_addr", imem_addr, 32'h0); chk("kb_req", {31'b0, imem_req}, 32'h1);
        chk("kb_valid", {31'b0, if_id_valid}, 32'h0);
        push_a(32'h0); push_i(32'h0, 32'h4, 32'h0);
        go(1, 0, 0, 0); chk("kb4_addr", imem_addr, 32'h4);
        push_a(32'h4); push_i(32'h4, 32'h8, 32'h4);
        go(0, 0, 0, 0);
        go(0, 0, 0, 0);
        #2;
        chk("sb_addr_left", exp_a.size(), 32'h0);
        chk("sb_ifid_left", exp_i.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I 5-stage pipeline. It owns the architectural fetch PC register and issues requests to instruction memory over a req/ready handshake. It fills the IF/ID pipeline register and applies redirects (pc_next/pcsrc) coming from the next-PC/branch-resolution logic. Stalls hold IF/ID; redirects flush it with a bubble.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- NOP_INSTR, 32'h0000_0013, instruction word driven on IF/ID during bubbles (addi x0,x0,0)

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- redirect  in  1  pcsrc from next-PC logic; take redirect_pc
- redirect_pc  in  32  target PC (pc_next); bits [1:0] forced to 0 internally
- stall  in  1  hazard unit: hold IF/ID contents
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  imem_rdata valid this cycle; completes the request
- imem_rdata  in  32  instruction word
- fetch_pc  out  32  current fetch PC register
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  32  PC of IF/ID instruction
- if_id_pc_plus4  out  32  if_id_pc + 4
- if_id_instr  out  32  instruction word or NOP_INSTR

## Operation
- States: BOOT, FETCH, KILL, HOLD. Reset state BOOT.
- Priority everywhere: redirect > stall > normal flow.
- BOOT: imem_req=0; next edge -> FETCH.
- FETCH: imem_req=1, imem_addr=fetch_pc.
  - imem_ready & redirect: data dropped; fetch_pc<=redirect_pc; IF/ID bubble; stay FETCH.
  - imem_ready & stall: data into hold_instr; IF/ID unchanged; -> HOLD.
  - imem_ready, else: IF/ID<={valid=1, fetch_pc, fetch_pc+4, imem_rdata}; fetch_pc<=fetch_pc+4; stay FETCH.
  - !imem_ready & redirect: pending_pc<=redirect_pc; IF/ID bubble; -> KILL (address must stay stable).
  - !imem_ready & stall: IF/ID unchanged.
  - !imem_ready, else: IF/ID bubble.
- KILL: imem_req=1, imem_addr=fetch_pc (old address held). Further redirect overwrites pending_pc. IF/ID bubble unless stall & !redirect. On imem_ready: data dropped, fetch_pc<=pending_pc (or redirect_pc if redirect this cycle), -> FETCH.
- HOLD: imem_req=0.
  - redirect: hold_instr discarded; fetch_pc<=redirect_pc; IF/ID bubble; -> FETCH.
  - !stall: IF/ID<={1, fetch_pc, fetch_pc+4, hold_instr}; fetch_pc<=fetch_pc+4; -> FETCH.
  - stall: no change.
- Bubble = if_id_valid 0, if_id_instr NOP_INSTR, if_id_pc/pc_plus4 hold their previous value.
- Handshake: once imem_req rises, imem_addr is constant until the imem_ready cycle. Back-to-back requests are allowed (req stays high after ready).
- Arithmetic: 32-bit, +4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.

## Timing
- Reset (async, any state, mid-request included): state BOOT, fetch_pc=RESET_PC, imem_req=0, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0, pending_pc=0, hold_instr=0. An in-flight memory response after reset is ignored (req=0 in BOOT).
- First imem_req: first cycle after the first clock edge following rst_n release.
- Zero-wait memory (ready in the req cycle): 1 instruction/cycle; IF/ID updates on the same edge as the ready cycle.
- Redirect penalty, zero-wait: 1 bubble; fetch of target is issued the cycle after redirect.
- Redirect during wait: bubble(s) until stale response returns, plus 1 bubble; target request issued the cycle after the stale ready.
- imem_req, imem_addr, if_id_* are registered or state-decoded only. No combinational path from redirect/stall to imem_addr.

## Test plan
- Reset release, always-ready memory returning addr-as-data: imem_addr 0,4,8,C on consecutive cycles; IF/ID shows pc 0,4,8 with instr equal to pc, valid=1 every cycle after the first.
- Zero-wait, redirect=1 redirect_pc=0x103 at fetch of 0x10: next imem_addr=0x100; IF/ID one bubble (instr 0x13, valid 0), then pc 0x100.
- imem_ready delayed 3 cycles on 0x20, redirect to 0x80 in cycle 1: imem_addr stays 0x20 until ready, stale word never reaches IF/ID, next imem_addr=0x80.
- stall asserted 2 cycles as 0x40 returns: req low 2 cycles, IF/ID holds previous instr; on release IF/ID=0x40 word, next addr 0x44.
- fetch_pc=0xFFFF_FFFC, no redirect: if_id_pc_plus4=0 and next imem_addr=0.
- rst_n dropped while in KILL: outputs take reset values immediately; after release first imem_addr=RESET_PC.
